// File: rtl/tcm_banked_mp.sv
// tcm_banked_mp: multi-port, banked tightly-coupled memory.
//
// Several requesters share BANK_NUM single-port, byte-write-enabled SRAM
// banks. Each bank runs its own round-robin arbiter, so requests that target
// different banks are accepted in the same cycle. Every accepted request gets
// its response exactly one cycle later. There is no response backpressure.
//
// Handshake: req_ready_o[p] is asserted only while req_valid_i[p] is high and
// port p holds its bank's grant. A request transfers on valid & ready. A
// requester that is not accepted keeps its request stable. rsp_valid_o[p] is
// a pulse one cycle after the transfer, and the requester must always accept it.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   req_valid_i    per-port request valid
//   req_ready_o    per-port request accepted this cycle
//   req_addr_i     per-port byte address (word-offset bits ignored)
//   req_we_i       per-port write (1) / read (0)
//   req_be_i       per-port byte enables for writes
//   req_wdata_i    per-port write data
//   rsp_valid_o    per-port response for last cycle's accepted request
//   rsp_rdata_o    per-port read data (holds last read value otherwise)
module tcm_banked_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192,
    parameter int BANK_DEPTH = 1024,
    parameter int NUM_PORTS  = 2,
    parameter int INTERLEAVE = 0,
    parameter int ADDR_WIDTH = $clog2(DEPTH*DATA_WIDTH/8)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_PORTS-1:0]                  req_valid_i,
    output logic [NUM_PORTS-1:0]                  req_ready_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_PORTS-1:0]                  req_we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_PORTS-1:0]                  rsp_valid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata_o
);
    localparam int BANK_NUM = DEPTH / BANK_DEPTH;
    localparam int NB       = DATA_WIDTH / 8;
    localparam int BO       = $clog2(NB);
    localparam int WA       = ADDR_WIDTH - BO;
    localparam int BW       = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int RW       = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Bank index from a byte address: contiguous (top bits) or interleaved (low bits).
    function automatic logic [BW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        logic [WA-1:0] w;
        w = WA'(a >> BO);
        if (BANK_NUM == 1) return '0;
        if (INTERLEAVE != 0) return BW'(int'(w) % BANK_NUM);
        return BW'(int'(w) / BANK_DEPTH);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        logic [WA-1:0] w;
        w = WA'(a >> BO);
        if (INTERLEAVE != 0) return RW'(int'(w) / BANK_NUM);
        return RW'(int'(w) % BANK_DEPTH);
    endfunction

    logic [BW-1:0]         req_bank   [NUM_PORTS];
    logic [RW-1:0]         req_row    [NUM_PORTS];
    logic [PW-1:0]         rr_ptr     [BANK_NUM];
    logic [BANK_NUM-1:0]   gnt_any;
    logic [PW-1:0]         gnt_port   [BANK_NUM];
    logic [BANK_NUM-1:0]   bank_en;
    logic [BANK_NUM-1:0]   bank_we;
    logic [NB-1:0]         bank_be    [BANK_NUM];
    logic [RW-1:0]         bank_row   [BANK_NUM];
    logic [DATA_WIDTH-1:0] bank_wdata [BANK_NUM];
    logic [DATA_WIDTH-1:0] bank_q     [BANK_NUM];

    logic [NUM_PORTS-1:0]                 rsp_valid;
    logic [NUM_PORTS-1:0]                 rsp_we;
    logic [BW-1:0]                        rsp_bank [NUM_PORTS];
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_hold;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_bank[p] = bank_of(req_addr_i[p]);
            req_row[p]  = row_of(req_addr_i[p]);
        end
    end

    // Per-bank round-robin: the first requester at or after the pointer wins.
    always_comb begin
        int q;
        q = 0;
        for (int b = 0; b < BANK_NUM; b++) begin
            gnt_any[b]  = 1'b0;
            gnt_port[b] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                q = (int'(rr_ptr[b]) + i) % NUM_PORTS;
                if (!gnt_any[b] && req_valid_i[q] && int'(req_bank[q]) == b) begin
                    gnt_any[b]  = 1'b1;
                    gnt_port[b] = PW'(q);
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_ready_o[p] = !rst_i && req_valid_i[p] && gnt_any[req_bank[p]]
                             && int'(gnt_port[req_bank[p]]) == p;
        end
    end

    // The winning port drives its bank's SRAM controls in the same cycle.
    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_en[b]    = gnt_any[b] && !rst_i;
            bank_we[b]    = req_we_i[gnt_port[b]];
            bank_be[b]    = req_be_i[gnt_port[b]];
            bank_row[b]   = req_row[gnt_port[b]];
            bank_wdata[b] = req_wdata_i[gnt_port[b]];
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] q;
        // The read register updates only on reads. It keeps its value across
        // writes, so a held read value is not disturbed.
        always_ff @(posedge clk_i) begin
            if (bank_en[b]) begin
                if (bank_we[b]) begin
                    for (int k = 0; k < NB; k++) begin
                        if (bank_be[b][k]) mem[bank_row[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
                    end
                end else begin
                    q <= mem[bank_row[b]];
                end
            end
        end
        assign bank_q[b] = q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < BANK_NUM; b++) rr_ptr[b] <= '0;
            for (int p = 0; p < NUM_PORTS; p++) rsp_bank[p] <= '0;
            rsp_valid  <= '0;
            rsp_we     <= '0;
            rdata_hold <= '0;
        end else begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (gnt_any[b]) rr_ptr[b] <= PW'((int'(gnt_port[b]) + 1) % NUM_PORTS);
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                rsp_valid[p] <= req_ready_o[p];
                if (req_ready_o[p]) begin
                    rsp_we[p]   <= req_we_i[p];
                    rsp_bank[p] <= req_bank[p];
                end
                if (rsp_valid[p] && !rsp_we[p]) rdata_hold[p] <= bank_q[rsp_bank[p]];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid_o[p] = rsp_valid[p];
            rsp_rdata_o[p] = (rsp_valid[p] && !rsp_we[p]) ? bank_q[rsp_bank[p]] : rdata_hold[p];
        end
    end
endmodule

// File: tb/tb_tcm_banked_mp.sv
// Directed bench for tcm_banked_mp. Instance 0 uses contiguous banking and
// instance 1 uses interleaved banking. Both use the default geometry of
// 8 banks x 1024 words x 32 bits and 2 ports.
module tb_tcm_banked_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        valid     [2];
    logic [1:0]        we        [2];
    logic [1:0]        ready     [2];
    logic [1:0]        rsp_valid [2];
    logic [1:0][14:0]  addr      [2];
    logic [1:0][3:0]   be        [2];
    logic [1:0][31:0]  wdata     [2];
    logic [1:0][31:0]  rdata     [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        tcm_banked_mp #(.INTERLEAVE(k)) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (valid[k]),
            .req_ready_o (ready[k]),
            .req_addr_i  (addr[k]),
            .req_we_i    (we[k]),
            .req_be_i    (be[k]),
            .req_wdata_i (wdata[k]),
            .rsp_valid_o (rsp_valid[k]),
            .rsp_rdata_o (rdata[k])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on one port. Checks that it is accepted at once, that the
    // response follows one cycle later, and that rdata matches exp. For a
    // write, exp is the value rdata must keep holding.
    task automatic single(input int k, input int p, input logic w, input logic [14:0] a,
                          input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp,
                          input string tag);
        @(negedge clk);
        valid[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; be[k][p] = b; wdata[k][p] = d;
        #1 check_eq({tag, "_rdy"}, 32'(ready[k][p]), 32'd1);
        @(negedge clk);
        valid[k][p] = 1'b0;
        #1 check_eq({tag, "_rv"}, 32'(rsp_valid[k][p]), 32'd1);
        check_eq({tag, "_rd"}, rdata[k][p], exp);
    endtask

    logic [1:0] exp_rdy;
    logic [1:0] prev;
    int n0, n1;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = '0; we[k] = '0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
        end
        // Reset state: ready is held low even with valid high.
        valid[0] = 2'b01;
        repeat (3) @(negedge clk);
        #1 check_eq("rst_rdy", 32'(ready[0]), 32'd0);
        check_eq("rst_rv", 32'(rsp_valid[0]), 32'd0);
        check_eq("rst_rdata", rdata[0][0], 32'd0);
        @(negedge clk);
        valid[0] = '0;
        rst = 1'b0;

        // Contiguous instance: basic write/read, byte enables, no-op write.
        single(0, 0, 1'b1, 15'h0000, 4'hF, 32'hDEADBEEF, 32'h0,        "wr0");
        single(0, 0, 1'b0, 15'h0000, 4'hF, 32'h0,        32'hDEADBEEF, "rd0");
        single(0, 0, 1'b1, 15'h0100, 4'hF, 32'h11223344, 32'hDEADBEEF, "wr100a");
        single(0, 0, 1'b1, 15'h0100, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF, "wr100b");
        single(0, 0, 1'b0, 15'h0100, 4'h0, 32'h0,        32'h11BB33DD, "rd100");
        single(0, 0, 1'b1, 15'h0100, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD, "wrbe0");
        single(0, 0, 1'b0, 15'h0100, 4'h0, 32'h0,        32'h11BB33DD, "rdbe0");
        // Contiguous mapping: 0x1000 is bank1 row0, so it does not alias 0x0000.
        single(0, 0, 1'b1, 15'h1000, 4'hF, 32'h5A5A5A5A, 32'h11BB33DD, "wr1000");
        single(0, 0, 1'b0, 15'h0000, 4'h0, 32'h0,        32'hDEADBEEF, "rd0_noalias");
        single(0, 0, 1'b0, 15'h1000, 4'h0, 32'h0,        32'h5A5A5A5A, "rd1000");

        // Interleaved instance: the two ports target banks 0 and 1 in parallel.
        @(negedge clk);
        valid[1] = 2'b11; we[1] = 2'b11; be[1] = {4'hF, 4'hF};
        addr[1][0] = 15'h0000; addr[1][1] = 15'h0004;
        wdata[1][0] = 32'h01010101; wdata[1][1] = 32'h02020202;
        #1 check_eq("par_w_rdy", 32'(ready[1]), 32'd3);
        @(negedge clk);
        valid[1] = 2'b00;
        #1 check_eq("par_w_rv", 32'(rsp_valid[1]), 32'd3);
        @(negedge clk);
        valid[1] = 2'b11; we[1] = 2'b00;
        #1 check_eq("par_r_rdy", 32'(ready[1]), 32'd3);
        @(negedge clk);
        valid[1] = 2'b00;
        #1 check_eq("par_r_rv", 32'(rsp_valid[1]), 32'd3);
        check_eq("par_r_d0", rdata[1][0], 32'h01010101);
        check_eq("par_r_d1", rdata[1][1], 32'h02020202);
        // 0x0020 is word 8, which is bank 0 row 1.
        single(1, 1, 1'b1, 15'h0020, 4'hF, 32'h03030303, 32'h02020202, "wr20");

        // Reset so the fairness run starts from pointer 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Both ports hold reads to bank 0 for 6 cycles, so the grants alternate.
        valid[1] = 2'b11; we[1] = 2'b00;
        addr[1][0] = 15'h0000; addr[1][1] = 15'h0020;
        prev = 2'b00; n0 = 0; n1 = 0;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c > 0) begin
                check_eq("fair_rv", 32'(rsp_valid[1]), 32'(prev));
                if (prev[0]) check_eq("fair_d0", rdata[1][0], 32'h01010101);
                if (prev[1]) check_eq("fair_d1", rdata[1][1], 32'h03030303);
                n0 += int'(rsp_valid[1][0]);
                n1 += int'(rsp_valid[1][1]);
            end
            if (c < 6) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                check_eq("fair_rdy", 32'(ready[1]), 32'(exp_rdy));
                prev = exp_rdy;
            end
            @(negedge clk);
            if (c == 5) valid[1] = 2'b00;
        end
        check_eq("fair_n0", 32'(n0), 32'd3);
        check_eq("fair_n1", 32'(n1), 32'd3);

        // Reset mid-operation. Port0 is accepted, which moves the bank 0
        // pointer to 1, and then reset hits. After release, port0 wins again.
        @(negedge clk);
        valid[1] = 2'b01; addr[1][0] = 15'h0000;
        #1 check_eq("mid_acc", 32'(ready[1]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        valid[1] = 2'b11; addr[1][1] = 15'h0020;
        #1 check_eq("mid_rst_rdy", 32'(ready[1]), 32'd0);
        @(negedge clk);
        #1 check_eq("mid_rst_rv", 32'(rsp_valid[1]), 32'd0);
        check_eq("mid_rst_rdy2", 32'(ready[1]), 32'd0);
        rst = 1'b0;
        #1 check_eq("mid_post_rdy", 32'(ready[1]), 32'd1);
        @(negedge clk);
        valid[1] = 2'b00;
        #1 check_eq("mid_post_rv", 32'(rsp_valid[1]), 32'd1);
        check_eq("mid_post_d", rdata[1][0], 32'h01010101);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tcm_banked_mp.md
Name: tcm_banked_mp

Overview:
- Multi-port, banked tightly-coupled memory for the core subsystem.
- Serves NUM_PORTS independent requesters (e.g. instruction fetch, LSU, DMA) over a valid/ready request channel with a fixed-latency response.
- Arbitrates per bank with round-robin, so requests to different banks complete in the same cycle.
- Bank selection is either high-address (contiguous) or word-interleaved. Each bank is a byte-write-enabled single-port SRAM macro, one access per cycle.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- DEPTH, 8192, total words; multiple of BANK_DEPTH.
- BANK_DEPTH, 1024, words per bank; power of 2.
- NUM_PORTS, 2, number of requesters, 1..4.
- INTERLEAVE, 0, 0 = bank from top address bits; 1 = bank from lowest word-address bits.
- ADDR_WIDTH, $clog2(DEPTH*DATA_WIDTH/8), byte address width.
- BANK_NUM (localparam), DEPTH/BANK_DEPTH, power of 2, 1..16.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  NUM_PORTS  request valid per port
- req_ready_o  out  NUM_PORTS  request accepted this cycle
- req_addr_i  in  NUM_PORTS x ADDR_WIDTH  byte address; low $clog2(DATA_WIDTH/8) bits ignored
- req_we_i  in  NUM_PORTS  1 = write, 0 = read
- req_be_i  in  NUM_PORTS x DATA_WIDTH/8  byte enables (writes only)
- req_wdata_i  in  NUM_PORTS x DATA_WIDTH  write data
- rsp_valid_o  out  NUM_PORTS  response for the request accepted in the previous cycle
- rsp_rdata_o  out  NUM_PORTS x DATA_WIDTH  read data; valid only when rsp_valid_o=1 and the request was a read

Behaviour:
- Clock, reset (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - rsp_valid_o=0, rsp_rdata_o=0, all round-robin pointers=0.
  - req_ready_o forced 0 while rst_i=1.
  - SRAM contents are not reset.
- Address decode, word address w = addr >> log2(DATA_WIDTH/8):
  - INTERLEAVE=0: bank = w[msb -: log2(BANK_NUM)], row = w mod BANK_DEPTH.
  - INTERLEAVE=1: bank = w mod BANK_NUM, row = w >> log2(BANK_NUM).
  - BANK_NUM=1: bank=0 for both modes.
- Arbitration:
  - Per bank, combinational, among ports with req_valid_i targeting that bank.
  - Round-robin: the grant goes to the first requesting port at or after the bank's pointer.
  - On a grant, the pointer becomes granted port+1 (mod NUM_PORTS). Pointers of banks without a grant hold.
- Handshake:
  - req_ready_o[p] = req_valid_i[p] & granted. Ready never asserts without valid.
  - A request is accepted when valid&ready.
  - An unaccepted requester must hold its request stable until accepted. The block does not check this.
- Access:
  - The accepted request drives its bank's en/we/be/row/wdata in the same cycle.
  - Write: only bytes with be=1 change.
  - A write with be=0 is legal and is a no-op write.
- Response latency:
  - Exactly 1 cycle after acceptance, for reads and writes.
  - rsp_valid_o[p] is a registered copy of (valid&ready)[p].
  - rsp_rdata_o[p] is muxed from the bank recorded for port p at acceptance (registered bank index per port).
  - There is no response backpressure; the requester must sink every response.
- rsp_rdata_o:
  - Holds its last read value when rsp_valid_o=0 and after write responses.
  - Equals the SRAM output only in read-response cycles.
- Throughput: one access per port per cycle when no bank conflict; up to min(NUM_PORTS, BANK_NUM) accesses per cycle.
- Hazards:
  - Read after write to the same word in the next cycle returns the new data.
  - Reads and writes to the same bank in the same cycle never occur, because of the arbitration.
- Reset mid-operation: accepted in-flight requests produce no response (rsp_valid_o=0 the cycle after reset asserts). Writes already issued to an SRAM may or may not have landed.
- Out-of-range addresses cannot occur; ADDR_WIDTH covers exactly DEPTH words.

Test Plan:
- Reset, then port0 writes 0xDEADBEEF to 0x0000 (be=4'hF), then reads 0x0000 -> ready same cycle; rsp_valid_o[0] one cycle after each acceptance; read rdata=0xDEADBEEF.
- Byte enables: write 0x11223344 to 0x0100 (be=F), then 0xAABBCCDD (be=4'b0101), then read -> rdata=0x11BB33DD.
- Parallel, INTERLEAVE=1, defaults (8 banks): port0 reads 0x0000 (bank0), port1 reads 0x0004 (bank1) in the same cycle -> both ready; both rsp_valid next cycle with the correct data.
- Conflict fairness: both ports hold reads to bank 0 (0x0000 and 0x0020 with INTERLEAVE=1) for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with port0 after reset; each port gets 3 responses.
- INTERLEAVE=0 mapping: write 0x5A5A5A5A to 0x1000 (bank1, row0); read 0x0000 (bank0) -> 0x5A5A5A5A is not returned; read 0x1000 -> 0x5A5A5A5A.
- Reset mid-operation: accept a port0 read, assert rst_i the next cycle -> rsp_valid_o=0 and req_ready_o=0 while reset is high; after release, round-robin restarts with port0 winning the first conflict.
